// File: rtl/data_sram_bridge_if.sv
// Split-handshake data SRAM bus: request/address phase (addr_ok) and data phase (data_ok).
interface data_sram_bridge_if;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata,
    input  addr_ok, data_ok, bus_rdata
  );

  modport slave (
    input  bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata,
    output addr_ok, data_ok, bus_rdata
  );
endinterface

// File: rtl/data_sram_bridge.sv
// Bridges single-cycle CPU memory-stage loads/stores onto the split-handshake SRAM bus,
// stalling the pipeline until the access completes, errors out or times out.
module data_sram_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cpu_ce,
  input  logic                       cpu_we,
  input  logic [31:0]                cpu_addr,
  input  logic [31:0]                cpu_wdata,
  input  logic [3:0]                 cpu_lsop,
  output logic [31:0]                cpu_rdata,
  output logic                       stallreq,
  output logic                       err,
  data_sram_bridge_if.master         bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
    OP_LW   = 4'd5, OP_SB = 4'd6, OP_SH  = 4'd7, OP_SW = 4'd8
  } lsop_e;

  localparam logic [31:0] TO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  state_e      state, state_d;
  logic [31:0] cnt, cnt_d;
  lsop_e       op_q;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [3:0]  strb_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        latch;

  // Decoded view of the incoming CPU request
  logic        op_known;
  logic        op_store;
  logic        align_ok;
  logic [1:0]  dec_size;
  logic [3:0]  dec_strb;
  logic [31:0] dec_wdata;
  logic        access;
  logic        timeout_hit;
  logic [31:0] load_ext;

  always_comb begin
    op_known  = 1'b1;
    op_store  = 1'b0;
    align_ok  = 1'b1;
    dec_size  = 2'd0;
    dec_strb  = '0;
    dec_wdata = '0;
    case (cpu_lsop)
      OP_LB, OP_LBU: dec_size = 2'd0;
      OP_LH, OP_LHU: begin
        dec_size = 2'd1;
        align_ok = ~cpu_addr[0];
      end
      OP_LW: begin
        dec_size = 2'd2;
        align_ok = (cpu_addr[1:0] == 2'b00);
      end
      OP_SB: begin
        op_store  = 1'b1;
        dec_size  = 2'd0;
        dec_strb  = 4'b0001 << cpu_addr[1:0];
        dec_wdata = {4{cpu_wdata[7:0]}};
      end
      OP_SH: begin
        op_store  = 1'b1;
        dec_size  = 2'd1;
        align_ok  = ~cpu_addr[0];
        dec_strb  = 4'b0011 << cpu_addr[1:0];
        dec_wdata = {2{cpu_wdata[15:0]}};
      end
      OP_SW: begin
        op_store  = 1'b1;
        dec_size  = 2'd2;
        align_ok  = (cpu_addr[1:0] == 2'b00);
        dec_strb  = 4'b1111;
        dec_wdata = cpu_wdata;
      end
      default: op_known = 1'b0;
    endcase
  end

  // A request whose cpu_we disagrees with its lsop is treated as no access
  assign access = cpu_ce && op_known && (cpu_we == op_store);

  assign stallreq = rst && access && (state != DONE);

  assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

  always_comb begin
    logic [4:0]  bsel;
    logic [7:0]  b;
    logic [15:0] h;
    bsel = {addr_q[1:0], 3'b000};
    b    = bus.bus_rdata[bsel +: 8];
    h    = addr_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (op_q)
      OP_LB:   load_ext = {{24{b[7]}}, b};
      OP_LBU:  load_ext = {24'd0, b};
      OP_LH:   load_ext = {{16{h[15]}}, h};
      OP_LHU:  load_ext = {16'd0, h};
      OP_LW:   load_ext = bus.bus_rdata;
      default: load_ext = '0;
    endcase
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    latch   = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          rdata_d = '0;
          if (align_ok) begin
            latch   = 1'b1;
            cnt_d   = '0;
            state_d = REQ;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      REQ: begin
        if (bus.addr_ok) begin
          if (bus.data_ok) begin
            if (!wr_q) rdata_d = load_ext;
            state_d = DONE;
          end else begin
            cnt_d   = '0;
            state_d = WAIT;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt + 32'd1;
        end
      end
      WAIT: begin
        if (bus.data_ok) begin
          if (!wr_q) rdata_d = load_ext;
          state_d = DONE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt + 32'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= OP_NONE;
      wr_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      strb_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (latch) begin
        op_q    <= lsop_e'(cpu_lsop);
        wr_q    <= op_store;
        size_q  <= dec_size;
        addr_q  <= cpu_addr;
        strb_q  <= dec_strb;
        wdata_q <= dec_wdata;
      end
    end
  end

  assign bus.bus_req   = (state == REQ);
  assign bus.bus_wr    = wr_q;
  assign bus.bus_size  = size_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wstrb = strb_q;
  assign bus.bus_wdata = wdata_q;

  assign cpu_rdata = rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed vector table plus hand-written misaligned, timeout and reset-abort sequences.
module tb_data_sram_bridge;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_ce = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [3:0]  cpu_lsop = '0;
  logic [31:0] cpu_rdata;
  logic        stallreq;
  logic        err;

  data_sram_bridge_if bus ();

  data_sram_bridge #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_ce    (cpu_ce),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_lsop  (cpu_lsop),
    .cpu_rdata (cpu_rdata),
    .stallreq  (stallreq),
    .err       (err),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  lsop;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  size;
    logic [3:0]  strb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One access with addr_ok/data_ok returned on the first REQ cycle
  task automatic run_vec(input vec_t v, input int idx);
    int  stalls;
    bit  seen;
    bit  done;
    @(posedge clk); #1;
    cpu_ce = 1'b1; cpu_we = v.we; cpu_lsop = v.lsop;
    cpu_addr = v.addr; cpu_wdata = v.wdata;
    bus.bus_rdata = v.rdata;
    stalls = 0; seen = 1'b0; done = 1'b0;
    for (int i = 0; i < 12 && !done; i++) begin
      @(negedge clk);
      if (stallreq) stalls++;
      else done = 1'b1;
      if (bus.bus_req) begin
        if (!seen) begin
          chk($sformatf("v%0d bus_addr", idx), bus.bus_addr, v.addr);
          chk($sformatf("v%0d bus_size", idx), 32'(bus.bus_size), 32'(v.size));
          chk($sformatf("v%0d bus_wr", idx), 32'(bus.bus_wr), 32'(v.we));
          chk($sformatf("v%0d bus_wstrb", idx), 32'(bus.bus_wstrb), 32'(v.strb));
          if (v.we) chk($sformatf("v%0d bus_wdata", idx), bus.bus_wdata, v.exp_wdata);
        end
        seen = 1'b1;
        bus.addr_ok = 1'b1; bus.data_ok = 1'b1;
      end else begin
        bus.addr_ok = 1'b0; bus.data_ok = 1'b0;
      end
    end
    chk($sformatf("v%0d req_seen", idx), 32'(seen), 32'd1);
    chk($sformatf("v%0d completed", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d stall_cycles", idx), 32'(stalls), 32'd2);
    chk($sformatf("v%0d cpu_rdata", idx), cpu_rdata, v.exp_rdata);
    chk($sformatf("v%0d err", idx), 32'(err), 32'd0);
    cpu_ce = 1'b0; cpu_lsop = 4'd0; cpu_we = 1'b0;
    bus.addr_ok = 1'b0; bus.data_ok = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int reqs;
    int stalls;
    bit done;

    //           lsop  we    addr          wdata         rdata         sz    strb     exp_wdata     exp_rdata
    vecs[0] = '{4'd5, 1'b0, 32'h0000_1000, 32'h0,        32'hDEAD_BEEF, 2'd2, 4'b0000, 32'h0,        32'hDEAD_BEEF};
    vecs[1] = '{4'd6, 1'b1, 32'h0000_1003, 32'h0000_00A5, 32'hFFFF_FFFF, 2'd0, 4'b1000, 32'hA5A5_A5A5, 32'h0};
    vecs[2] = '{4'd1, 1'b0, 32'h0000_2001, 32'h0,        32'h0000_8000, 2'd0, 4'b0000, 32'h0,        32'hFFFF_FF80};
    vecs[3] = '{4'd4, 1'b0, 32'h0000_2002, 32'h0,        32'h8001_0000, 2'd1, 4'b0000, 32'h0,        32'h0000_8001};
    vecs[4] = '{4'd7, 1'b1, 32'h0000_4002, 32'h1234_BEEF, 32'hFFFF_FFFF, 2'd1, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    vecs[5] = '{4'd8, 1'b1, 32'h0000_5000, 32'hCAFE_F00D, 32'hFFFF_FFFF, 2'd2, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[6] = '{4'd2, 1'b0, 32'h0000_6003, 32'h0,        32'h9A00_0000, 2'd0, 4'b0000, 32'h0,        32'h0000_009A};
    vecs[7] = '{4'd3, 1'b0, 32'h0000_7000, 32'h0,        32'h0000_8765, 2'd1, 4'b0000, 32'h0,        32'hFFFF_8765};

    bus.addr_ok = 1'b0; bus.data_ok = 1'b0; bus.bus_rdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst bus_req", 32'(bus.bus_req), 32'd0);
    chk("rst stallreq", 32'(stallreq), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst cpu_rdata", cpu_rdata, 32'd0);
    chk("rst bus_wstrb", 32'(bus.bus_wstrb), 32'd0);
    chk("rst bus_addr", bus.bus_addr, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Misaligned LH: error pulse, no bus access, one stall cycle
    @(posedge clk); #1;
    cpu_ce = 1'b1; cpu_we = 1'b0; cpu_lsop = 4'd3; cpu_addr = 32'h0000_3001;
    bus.bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("mis stall_first", 32'(stallreq), 32'd1);
    chk("mis req_first", 32'(bus.bus_req), 32'd0);
    @(negedge clk);
    chk("mis stall_done", 32'(stallreq), 32'd0);
    chk("mis err_done", 32'(err), 32'd1);
    chk("mis req_done", 32'(bus.bus_req), 32'd0);
    chk("mis cpu_rdata", cpu_rdata, 32'd0);
    cpu_ce = 1'b0; cpu_lsop = 4'd0;
    @(negedge clk);
    chk("mis err_after", 32'(err), 32'd0);
    chk("mis req_after", 32'(bus.bus_req), 32'd0);

    // addr_ok never arrives: bus_req for TIMEOUT cycles then error
    @(posedge clk); #1;
    cpu_ce = 1'b1; cpu_we = 1'b0; cpu_lsop = 4'd5; cpu_addr = 32'h0000_8000;
    reqs = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.bus_req) reqs++;
      if (!stallreq) done = 1'b1;
    end
    chk("to_req completed", 32'(done), 32'd1);
    chk("to_req req_cycles", 32'(reqs), 32'(TO));
    chk("to_req err", 32'(err), 32'd1);
    chk("to_req req_done", 32'(bus.bus_req), 32'd0);
    chk("to_req cpu_rdata", cpu_rdata, 32'd0);
    cpu_ce = 1'b0; cpu_lsop = 4'd0;
    @(negedge clk);
    chk("to_req err_after", 32'(err), 32'd0);

    // addr_ok given but data_ok never: WAIT times out
    @(posedge clk); #1;
    cpu_ce = 1'b1; cpu_we = 1'b0; cpu_lsop = 4'd5; cpu_addr = 32'h0000_8004;
    stalls = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (stallreq) stalls++;
      else done = 1'b1;
      bus.addr_ok = bus.bus_req;
    end
    bus.addr_ok = 1'b0;
    chk("to_wait completed", 32'(done), 32'd1);
    chk("to_wait stall_cycles", 32'(stalls), 32'(2 + TO));
    chk("to_wait err", 32'(err), 32'd1);
    cpu_ce = 1'b0; cpu_lsop = 4'd0;

    // Reset while in WAIT aborts; a later data_ok is ignored
    @(posedge clk); #1;
    cpu_ce = 1'b1; cpu_we = 1'b0; cpu_lsop = 4'd5; cpu_addr = 32'h0000_9000;
    bus.bus_rdata = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    chk("rw req_in_req", 32'(bus.bus_req), 32'd1);
    bus.addr_ok = 1'b1;
    @(negedge clk);
    bus.addr_ok = 1'b0;
    chk("rw req_in_wait", 32'(bus.bus_req), 32'd0);
    chk("rw stall_in_wait", 32'(stallreq), 32'd1);
    rst = 1'b0;
    #1;
    chk("rw stall_in_reset", 32'(stallreq), 32'd0);
    chk("rw req_in_reset", 32'(bus.bus_req), 32'd0);
    cpu_ce = 1'b0; cpu_lsop = 4'd0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.data_ok = 1'b1;
    @(negedge clk);
    bus.data_ok = 1'b0;
    chk("rw late cpu_rdata", cpu_rdata, 32'd0);
    chk("rw late err", 32'(err), 32'd0);
    chk("rw late stall", 32'(stallreq), 32'd0);
    chk("rw late req", 32'(bus.bus_req), 32'd0);

    // Normal traffic resumes after the abort
    run_vec(vecs[0], 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
